// File: rtl/oam_scan_if.sv
// OAM read bus between the sprite scanner (master) and the OAM RAM (slave).
// The RAM returns the addressed Y/X word one cycle after the read strobe.
interface oam_scan_if;
    logic [7:0]  oam_adr;
    logic        oam_read;
    logic [15:0] oam_dout16;

    modport master (
        output oam_adr,
        output oam_read,
        input  oam_dout16
    );

    modport slave (
        input  oam_adr,
        input  oam_read,
        output oam_dout16
    );
endinterface

// File: rtl/oam_scan.sv
// Per-line sprite search: walks all OAM entries and buffers up to MAX_SPRITES visible ones.
// Optional macro OAM_SCAN_OVF_EN adds the ovf / ovf_cnt overflow reporting outputs.
module oam_scan #(
    parameter int NUM_ENTRIES = 40,
    parameter int MAX_SPRITES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ly,
    input  logic        obj_size,
    oam_scan_if.master  oam,
    output logic        busy,
    output logic        done,
    output logic [3:0]  count,
    input  logic [3:0]  buf_sel,
    output logic [7:0]  buf_x,
    output logic [5:0]  buf_num,
    output logic [3:0]  buf_row
`ifdef OAM_SCAN_OVF_EN
    ,
    output logic        ovf,
    output logic [4:0]  ovf_cnt
`endif
);

    localparam logic [5:0] LAST_IDX  = 6'(NUM_ENTRIES - 1);
    localparam logic [3:0] SLOT_LIM  = 4'(MAX_SPRITES);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    state_t      state;
    logic [5:0]  idx;
    logic [5:0]  pidx;
    logic        p;
    logic [7:0]  ly_q;
    logic        size_q;

    logic [7:0]  slot_x   [MAX_SPRITES];
    logic [5:0]  slot_num [MAX_SPRITES];
    logic [3:0]  slot_row [MAX_SPRITES];

    logic [8:0]  t;
    logic [8:0]  y9;
    logic [8:0]  y_end;
    logic [3:0]  row;
    logic        hit;
    logic        room;

    // Visibility test on the word returned for entry pidx; all 9-bit so Y near 255 never wraps.
    always_comb begin
        t     = {1'b0, ly_q} + 9'd16;
        y9    = {1'b0, oam.oam_dout16[7:0]};
        y_end = y9 + (size_q ? 9'd16 : 9'd8);
        row   = t[3:0] - y9[3:0];
        hit   = p && (y9 <= t) && (t < y_end);
        room  = (count < SLOT_LIM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            pidx         <= '0;
            p            <= 1'b0;
            ly_q         <= '0;
            size_q       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            count        <= '0;
            oam.oam_read <= 1'b0;
            oam.oam_adr  <= '0;
            for (int i = 0; i < MAX_SPRITES; i++) begin
                slot_x[i]   <= '0;
                slot_num[i] <= '0;
                slot_row[i] <= '0;
            end
`ifdef OAM_SCAN_OVF_EN
            ovf          <= 1'b0;
            ovf_cnt      <= '0;
`endif
        end else begin
            done <= 1'b0;

            if (hit) begin
                if (room) begin
                    slot_x[count]   <= oam.oam_dout16[15:8];
                    slot_num[count] <= pidx;
                    slot_row[count] <= row;
                    count           <= count + 4'd1;
                end
`ifdef OAM_SCAN_OVF_EN
                else begin
                    ovf <= 1'b1;
                    if (ovf_cnt != 5'd31) begin
                        ovf_cnt <= ovf_cnt + 5'd1;
                    end
                end
`endif
            end

            case (state)
                IDLE: begin
                    p <= 1'b0;
                    if (start) begin
                        ly_q         <= ly;
                        size_q       <= obj_size;
                        count        <= '0;
                        idx          <= '0;
                        busy         <= 1'b1;
                        oam.oam_read <= 1'b1;
                        oam.oam_adr  <= '0;
                        state        <= SCAN;
`ifdef OAM_SCAN_OVF_EN
                        ovf          <= 1'b0;
                        ovf_cnt      <= '0;
`endif
                    end
                end

                // Address is registered one step ahead so it tracks idx in the cycle it is issued.
                SCAN: begin
                    idx  <= idx + 6'd1;
                    p    <= 1'b1;
                    pidx <= idx;
                    if (idx == LAST_IDX) begin
                        oam.oam_read <= 1'b0;
                        oam.oam_adr  <= '0;
                        state        <= DRAIN;
                    end else begin
                        oam.oam_adr  <= {idx + 6'd1, 2'b00};
                    end
                end

                DRAIN: begin
                    p     <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    p     <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Slots at or beyond count are stale; the fetcher only reads below count.
    always_comb begin
        buf_x   = '0;
        buf_num = '0;
        buf_row = '0;
        if (buf_sel < SLOT_LIM) begin
            buf_x   = slot_x[buf_sel];
            buf_num = slot_num[buf_sel];
            buf_row = slot_row[buf_sel];
        end
    end

endmodule
